// File: rtl/wb_console_tx.sv
// Wishbone byte sink that buffers console output in a FIFO and serializes it as 8N1 UART on o_tx.
// Optional macro WB_CONSOLE_DROP_ON_FULL_EN: discard writes to a full FIFO (counted) instead of stalling.
module wb_console_tx #(
    parameter int CLK_DIV    = 434,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx
);
    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    localparam int          CW          = DEPTH_LOG2 + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e                state_q;
    logic [7:0]            shift_q;
    logic [2:0]            bit_cnt_q;
    logic [15:0]           baud_q;
    logic                  tx_q;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ack_q, ack_d;
    logic [31:0]           rdt_q, rdt_d;
    logic [7:0]            ovf_q, ovf_d;

    logic                  full_s, empty_s, busy_s;
    logic                  pending_s, push_s, pop_s;
    logic [8:0]            count_ext_s;
    logic [7:0]            fill_s;
    logic                  unused_s;

    assign unused_s = ^i_wb_dat[31:8];

    // Bus decode, FIFO bookkeeping and status word.
    always_comb begin
        full_s      = (count_q == CW'(DEPTH));
        empty_s     = (count_q == CW'(0));
        busy_s      = (state_q != S_IDLE);
        pending_s   = i_wb_cyc & i_wb_stb & ~ack_q;
        push_s      = pending_s & i_wb_we & ~full_s;
        // The FSM takes a byte from IDLE, or straight out of an expiring stop bit.
        pop_s       = ~empty_s & ((state_q == S_IDLE) |
                                  ((state_q == S_STOP) & (baud_q == 16'd0)));
        count_ext_s = 9'(count_q);
        if (count_ext_s > 9'd255) begin
            fill_s = 8'hFF;
        end else begin
            fill_s = count_ext_s[7:0];
        end

`ifdef WB_CONSOLE_DROP_ON_FULL_EN
        ack_d = pending_s;
        if (pending_s & i_wb_we & full_s & (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end else begin
            ovf_d = ovf_q;
        end
`else
        ack_d = pending_s & (~i_wb_we | ~full_s);
        ovf_d = 8'h00;
`endif

        if (pending_s & ~i_wb_we) begin
            rdt_d = {8'h00, ovf_q, fill_s, 5'b00000, busy_s, empty_s, full_s};
        end else begin
            rdt_d = 32'h0000_0000;
        end

        if (push_s) begin
            wptr_d = wptr_q + DEPTH_LOG2'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + DEPTH_LOG2'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Bus and FIFO state registers.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
            rdt_q   <= 32'h0000_0000;
            ovf_q   <= 8'h00;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            rdt_q   <= rdt_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge i_wb_clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= i_wb_dat[7:0];
        end
    end

    // UART transmit FSM; o_tx is registered here.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            baud_q    <= 16'd0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        shift_q   <= mem_q[rptr_q];
                        bit_cnt_q <= 3'd0;
                        baud_q    <= BAUD_RELOAD;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_q == 16'd0) begin
                        tx_q    <= shift_q[0];
                        baud_q  <= BAUD_RELOAD;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_q == 16'd0) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_q == 16'd0) begin
                        if (pop_s) begin
                            shift_q   <= mem_q[rptr_q];
                            bit_cnt_q <= 3'd0;
                            baud_q    <= BAUD_RELOAD;
                            tx_q      <= 1'b0;
                            state_q   <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_tx     = tx_q;

endmodule

// File: tb/tb_wb_console_tx.sv
// Directed self-checking bench for wb_console_tx at CLK_DIV=4, DEPTH_LOG2=2 with a cycle-based UART decoder.
module tb_wb_console_tx;
    localparam int CD = 4;

    logic        clk;
    logic        rst;
    logic [31:0] dat;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;
    logic        tx;

    int n_pass = 0;
    int n_total = 0;

    wb_console_tx #(.CLK_DIV(CD), .DEPTH_LOG2(2)) dut (
        .i_wb_clk(clk),
        .i_wb_rst(rst),
        .i_wb_dat(dat),
        .i_wb_we (we),
        .i_wb_cyc(cyc),
        .i_wb_stb(stb),
        .o_wb_rdt(rdt),
        .o_wb_ack(ack),
        .o_tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle-based UART receiver: samples mid-bit, records frame start cycles.
    int         cyc_n = 0;
    int         rx_cnt = -1;
    int         rx_bad = 0;
    logic [9:0] rx_sh;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always @(posedge clk) begin
        #3;
        cyc_n++;
        if (rst) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (tx == 1'b0) begin
                rx_cnt = 0;
                rx_t.push_back(cyc_n);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CD == CD / 2) rx_sh[rx_cnt / CD] = tx;
            if (rx_cnt == 9 * CD + CD / 2) begin
                rx_q.push_back(rx_sh[8:1]);
                if (rx_sh[0] !== 1'b0 || rx_sh[9] !== 1'b1) rx_bad++;
                rx_cnt = -1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wb_write(input logic [7:0] d, output int lat);
        lat = -1;
        dat = {24'hDEAD_BE, d};
        we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (ack) begin lat = i; break; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_read(output logic [31:0] d, output int lat);
        lat = -1;
        d = 32'hFFFF_FFFF;
        we = 1'b0; cyc = 1'b1; stb = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (ack) begin lat = i; d = rdt; break; end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] st;
        int          lat;
        int          lsum;
        logic [41:0] obs;
        logic [41:0] exp;
        logic [9:0]  frame;
        logic [7:0]  bytes6 [6];

        rst = 1'b1; dat = 32'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_tx", {63'h0, tx}, 64'h1);
        check("rst_ack", {63'h0, ack}, 64'h0);
        check("rst_rdt", {32'h0, rdt}, 64'h0);
        wb_read(st, lat);
        check("rst_status", {32'h0, st}, 64'h0000_0002);
        check("read_lat", lat, 1);

        // Single byte, cycle-exact waveform
        wb_write(8'h41, lat);
        check("wr_lat", lat, 1);
        frame = {1'b1, 8'h41, 1'b0};
        for (int i = 0; i < 42; i++) begin
            exp[i] = (i < 40) ? frame[i / CD] : 1'b1;
        end
        obs[0] = tx;
        for (int i = 1; i < 42; i++) begin
            @(posedge clk); #1;
            obs[i] = tx;
        end
        check("single_wave", {22'h0, obs}, {22'h0, exp});
        wait_rx(1, 20);
        check("single_rx_n", rx_q.size(), 1);
        check("single_rx_b", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h41);
        rx_q.delete(); rx_t.delete();
        wait_cycles(5);

        // Back-to-back frames
        wb_write(8'h55, lat);
        wb_write(8'hAA, lat);
        wait_cycles(8);
        wb_read(st, lat);
        check("b2b_status", {32'h0, st}, 64'h0000_0104);
        wait_rx(2, 200);
        check("b2b_rx_n", rx_q.size(), 2);
        if (rx_q.size() == 2 && rx_t.size() == 2) begin
            check("b2b_rx_0", rx_q[0], 8'h55);
            check("b2b_rx_1", rx_q[1], 8'hAA);
            check("b2b_gap", rx_t[1] - rx_t[0], 10 * CD);
        end
        rx_q.delete(); rx_t.delete();
        wait_cycles(10);
        wb_read(st, lat);
        check("idle_status", {32'h0, st}, 64'h0000_0002);

        // Full FIFO: six quick writes into a 4-deep FIFO
        bytes6[0] = 8'h11; bytes6[1] = 8'h22; bytes6[2] = 8'h33;
        bytes6[3] = 8'h44; bytes6[4] = 8'h58; bytes6[5] = 8'hC6;
        lsum = 0;
        for (int i = 0; i < 5; i++) begin
            wb_write(bytes6[i], lat);
            lsum += lat;
        end
        check("full_lat_1to5", lsum, 5);
`ifdef WB_CONSOLE_DROP_ON_FULL_EN
        wb_write(bytes6[5], lat);
        check("drop_lat6", lat, 1);
        wb_read(st, lat);
        check("drop_status", {32'h0, st}, 64'h0001_0405);
        wait_rx(5, 400);
        check("drop_rx_n", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check("drop_rx_b", rx_q[i], bytes6[i]);
        end
`else
        wb_write(bytes6[5], lat);
        check("stall_lat6", lat, 33);
        wait_rx(6, 400);
        check("stall_rx_n", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) check("stall_rx_b", rx_q[i], bytes6[i]);
        end
`endif
        rx_q.delete(); rx_t.delete();
        wait_cycles(10);

        // Reset during data bit 3 with a byte still queued
        wb_write(8'h3C, lat);
        wb_write(8'h77, lat);
        for (int i = 0; i < 100 && rx_cnt != 17; i++) begin
            @(posedge clk); #1;
        end
        check("mid_reached", rx_cnt, 17);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tx", {63'h0, tx}, 64'h1);
        check("mid_rst_ack", {63'h0, ack}, 64'h0);
        rst = 1'b0;
        wb_read(st, lat);
        check("mid_rst_status", {32'h0, st}, 64'h0000_0002);
        wait_cycles(50);
        check("mid_no_rx", rx_q.size(), 0);
        wb_write(8'h0F, lat);
        check("post_wr_lat", lat, 1);
        wait_rx(1, 100);
        check("post_rx_n", rx_q.size(), 1);
        check("post_rx_b", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h0F);
        wait_cycles(10);
        check("post_tx_idle", {63'h0, tx}, 64'h1);
        check("frame_bits_ok", rx_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
